// File: rtl/shreg_pkg.sv
// Shared mode encodings for the universal shift register.
package shreg_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_CLR  = 3'b110,
      MODE_RSV  = 3'b111
   } mode_e;

endpackage

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/clear with registered zero flag.
// One clock from sampled inputs to Q/ZERO; no backpressure, CE low simply holds state.
module univ_shift_reg
   import shreg_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              SRST_N,
   input  logic              CE,
   input  logic [MODE_W-1:0] MODE,
   input  logic [WIDTH-1:0]  D,
   input  logic              SIN_L,
   input  logic              SIN_R,
   output logic [WIDTH-1:0]  Q,
   output logic              SO_MSB,
   output logic              SO_LSB,
   output logic              ZERO
);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic             zero_r;

   function automatic logic [WIDTH-1:0] mode_next(
      input logic [WIDTH-1:0]  q,
      input logic [WIDTH-1:0]  d,
      input logic              sin_l,
      input logic              sin_r,
      input logic [MODE_W-1:0] mode
   );
      logic [WIDTH-1:0] r;
      r = q;
      case (mode_e'(mode))
         MODE_LOAD: r = d;
         MODE_SHL:  r = {q[WIDTH-2:0], sin_l};
         MODE_SHR:  r = {sin_r, q[WIDTH-1:1]};
         MODE_ROL:  r = {q[WIDTH-2:0], q[WIDTH-1]};
         MODE_ROR:  r = {q[0], q[WIDTH-1:1]};
         MODE_CLR:  r = RST_VAL;
         default:   r = q;
      endcase
      return r;
   endfunction

   always_comb begin
      q_nxt = q_r;
      if (!SRST_N)
         q_nxt = RST_VAL;
      else if (CE)
         q_nxt = mode_next(q_r, D, SIN_L, SIN_R, MODE);
   end

   // Zero flag is taken from the next-state value so it never lags Q.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         q_r    <= RST_VAL;
         zero_r <= (RST_VAL == '0);
      end else begin
         q_r    <= q_nxt;
         zero_r <= (q_nxt == '0);
      end
   end

   assign Q      = q_r;
   assign ZERO   = zero_r;
   assign SO_MSB = q_r[WIDTH-1];
   assign SO_LSB = q_r[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: default-reset and RST_VAL=5A instances.
module tb_univ_shift_reg;
   import shreg_pkg::*;

   logic              CLK = 1'b0;
   logic              RESET = 1'b1;
   logic              reset2 = 1'b1;
   logic              SRST_N = 1'b1;
   logic              CE = 1'b1;
   logic [MODE_W-1:0] MODE = MODE_HOLD;
   logic [7:0]        D = 8'h00;
   logic              SIN_L = 1'b0;
   logic              SIN_R = 1'b0;
   logic [7:0]        q1, q2;
   logic              so_msb1, so_lsb1, zero1;
   logic              so_msb2, so_lsb2, zero2;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) u_dut (
      .CLK(CLK), .RESET(RESET), .SRST_N(SRST_N), .CE(CE), .MODE(MODE),
      .D(D), .SIN_L(SIN_L), .SIN_R(SIN_R),
      .Q(q1), .SO_MSB(so_msb1), .SO_LSB(so_lsb1), .ZERO(zero1)
   );

   univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h5A)) u_dut2 (
      .CLK(CLK), .RESET(reset2), .SRST_N(SRST_N), .CE(CE), .MODE(MODE),
      .D(D), .SIN_L(SIN_L), .SIN_R(SIN_R),
      .Q(q2), .SO_MSB(so_msb2), .SO_LSB(so_lsb2), .ZERO(zero2)
   );

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   logic [7:0] rol_exp [8] = '{8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5};

   initial begin
      #3;
      RESET  = 1'b0;
      reset2 = 1'b0;
      #1;
      check("async_rst_q", q1, 8'h00);
      check("async_rst_zero", {7'd0, zero1}, 8'h01);
      check("async_rst_q2", q2, 8'h5A);
      check("async_rst_zero2", {7'd0, zero2}, 8'h00);
      @(negedge CLK);
      RESET  = 1'b1;
      reset2 = 1'b1;
      MODE   = MODE_LOAD;
      D      = 8'hA5;
      tick();
      check("load_a5", q1, 8'hA5);
      check("load_a5_zero", {7'd0, zero1}, 8'h00);

      MODE = MODE_ROL;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("rol_%0d", i), q1, rol_exp[i]);
      end
      MODE = MODE_ROR;
      tick();
      check("ror_1", q1, 8'hD2);

      MODE = MODE_LOAD;
      D    = 8'h81;
      tick();
      check("so_msb_81", {7'd0, so_msb1}, 8'h01);
      check("so_lsb_81", {7'd0, so_lsb1}, 8'h01);
      MODE  = MODE_SHL;
      SIN_L = 1'b0;
      tick();
      check("shl_02", q1, 8'h02);
      check("so_msb_02", {7'd0, so_msb1}, 8'h00);
      check("so_lsb_02", {7'd0, so_lsb1}, 8'h00);
      MODE  = MODE_SHR;
      SIN_R = 1'b1;
      tick();
      check("shr_81", q1, 8'h81);

      MODE = MODE_LOAD;
      D    = 8'hFF;
      tick();
      check("load_ff", q1, 8'hFF);
      SRST_N = 1'b0;
      D      = 8'h3C;
      tick();
      check("srst_over_load", q1, 8'h00);
      check("srst_zero", {7'd0, zero1}, 8'h01);
      CE = 1'b0;
      tick();
      check("srst_ce0", q1, 8'h00);
      check("srst_q2", q2, 8'h5A);

      SRST_N = 1'b1;
      CE     = 1'b1;
      tick();
      check("load_3c", q1, 8'h3C);
      CE   = 1'b0;
      MODE = MODE_SHL;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("ce0_hold_%0d", i), q1, 8'h3C);
      end
      CE   = 1'b1;
      MODE = MODE_RSV;
      tick();
      check("rsv_hold", q1, 8'h3C);

      MODE  = MODE_SHL;
      SIN_L = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      check("shl8_fill", q1, 8'hFF);

      // Mid-cycle async reset on the primary instance.
      #1;
      RESET = 1'b0;
      #1;
      check("mid_rst_q", q1, 8'h00);
      check("mid_rst_zero", {7'd0, zero1}, 8'h01);
      RESET = 1'b1;

      MODE = MODE_LOAD;
      D    = 8'h11;
      tick();
      check("load_11_q2", q2, 8'h11);
      #1;
      reset2 = 1'b0;
      #1;
      check("mid_rst_q2", q2, 8'h5A);
      check("mid_rst_zero2", {7'd0, zero2}, 8'h00);
      reset2 = 1'b1;
      D = 8'h00;
      tick();
      check("load_00_zero2", {7'd0, zero2}, 8'h01);
      MODE = MODE_CLR;
      tick();
      check("clr_q2", q2, 8'h5A);
      check("clr_zero2", {7'd0, zero2}, 8'h00);
      check("clr_q1", q1, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register built from D-FFs with both asynchronous and synchronous reset, plus clock enable and eight operating modes: hold, parallel load, logical shift left/right, rotate left/right, and synchronous clear. It is the general-purpose storage and serialisation element for the exercise datapaths. It replaces single-bit flip-flops wherever a multi-bit register, serialiser or deserialiser is needed.

## Interface
- WIDTH, 8, register width in bits (≥2)
- RST_VAL, {WIDTH{1'b0}}, value loaded by async reset, sync reset and CLEAR mode

- CLK  in  1  clock, all state captured on rising edge
- RESET  in  1  reset RESET, asynchronous, active-low; Q forced to RST_VAL immediately while low
- SRST_N  in  1  synchronous reset, active-low, sampled at posedge CLK
- CE  in  1  clock enable, active-high
- MODE  in  3  operation select (see Operation)
- D  in  WIDTH  parallel load data
- SIN_L  in  1  serial input entering bit 0 on shift left
- SIN_R  in  1  serial input entering bit WIDTH-1 on shift right
- Q  out  WIDTH  register contents
- SO_MSB  out  1  Q[WIDTH-1], combinational from Q
- SO_LSB  out  1  Q[0], combinational from Q
- ZERO  out  1  registered flag: 1 when Q == 0 (tracks Q with no added latency)

## Operation
- Priority at each posedge CLK: RESET low > SRST_N low > CE low > MODE.
- RESET low: Q = RST_VAL and ZERO = (RST_VAL == 0) asynchronously; both held until RESET rises; no edge required.
- SRST_N low at posedge: Q ← RST_VAL regardless of CE and MODE.
- CE low: Q holds.
- MODE decoding (CE=1, SRST_N=1):
  - 000 HOLD: Q ← Q
  - 001 LOAD: Q ← D
  - 010 SHL: Q ← {Q[WIDTH-2:0], SIN_L}
  - 011 SHR: Q ← {SIN_R, Q[WIDTH-1:1]}
  - 100 ROL: Q ← {Q[WIDTH-2:0], Q[WIDTH-1]}
  - 101 ROR: Q ← {Q[0], Q[WIDTH-1:1]}
  - 110 CLEAR: Q ← RST_VAL
  - 111 reserved, behaves as HOLD
- ZERO is computed from the next-state value and registered alongside Q, so ZERO always equals (Q == 0) after every edge.
- SO_MSB/SO_LSB reflect the current Q, so they equal the bit shifted out on the next SHL/SHR edge.

## Timing
- Latency: one clock from sampled inputs to Q/ZERO.
- Inputs D, MODE, CE, SRST_N, SIN_L, SIN_R must be stable around the rising edge; changes between edges have no effect.
- Async assertion of RESET mid-cycle clears Q in the same timestep. Deassertion must be synchronised upstream; the first posedge after release performs a normal operation.
- RESET low coincident with a rising edge: reset wins, and Q = RST_VAL.
- SRST_N low and MODE=LOAD on the same edge: Q = RST_VAL (SRST_N wins).
- WIDTH shifts of SHL with SIN_L constant fully replace Q; WIDTH rotates return Q to its original value.

## Structure
- Package shreg_pkg: MODE encodings as localparam/enum (MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_CLR, MODE_RSV) and MODE width constant (3).
- Next-state mux is a single combinational function of Q, D, SIN_L, SIN_R and MODE. The register is one always block sensitive to posedge CLK and negedge RESET.
- No sub-module required. A per-bit cell is not used, because rotate/shift need neighbour bits.

## Test plan
- WIDTH=8, RST_VAL=8'h00. RESET low at t=3ns, no clock edge → Q=8'h00, ZERO=1 immediately. Release, LOAD D=8'hA5 → next edge Q=8'hA5, ZERO=0.
- Q=8'hA5, ROL ×8 → sequence 4B,96,2D,5A,B4,69,D2,A5. Then ROR ×1 → D2.
- Q=8'h81, SHL with SIN_L=0 → 02. SHR with SIN_R=1 → 81 after shifting 02. Check SO_MSB/SO_LSB before each edge.
- Q=8'hFF, SRST_N low with MODE=LOAD, D=8'h3C → Q=8'h00. Same edge repeated with CE=0 → still 8'h00.
- CE=0 for 3 edges with MODE=SHL → Q unchanged. MODE=111 → hold.
- Second instance with RST_VAL=8'h5A: RESET pulse mid-cycle → Q=8'h5A, ZERO=0. CLEAR mode → 8'h5A.
